// File: rtl/sa_data_mover_pkg.sv
// Shared GEMM constants for the systolic-array output path.
// Lane geometry defaults used by the data mover and its lane delays.
package sa_data_mover_pkg;

   localparam int unsigned LaneWidth = 8;
   localparam int unsigned PeSize    = 14;
   localparam int unsigned RowWidth  = LaneWidth * PeSize;

   typedef logic [RowWidth-1:0] row_t;

endpackage

// File: rtl/lane_delay.sv
// Fixed-latency delay line for one systolic-array output lane.
// DELAY=0 degenerates to a plain wire.
module lane_delay
   import sa_data_mover_pkg::*;
#(
   parameter int unsigned DELAY = 1,
   parameter int unsigned WIDTH = LaneWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   if (DELAY == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign data_o = data_i;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(DELAY); i++) begin
               stage_q[i] <= '0;
            end
         end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < int'(DELAY); i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign data_o = stage_q[DELAY-1];
   end

endmodule

// File: rtl/sa_data_mover.sv
// Output-side data mover: de-skews systolic-array result lanes into aligned rows
// and writes one row per valid cycle into memory 0 with a wrapping address.
module sa_data_mover
   import sa_data_mover_pkg::*;
#(
   parameter int unsigned FIFO_DATA_WIDTH = LaneWidth,
   parameter int unsigned FIFO_DEPTH      = 14,
   parameter int unsigned PE_SIZE         = PeSize,
   parameter int unsigned MEM0_DEPTH      = 896,
   parameter int unsigned MEM1_DEPTH      = 896,
   parameter int unsigned MEM0_ADDR_WIDTH = 10,
   parameter int unsigned MEM1_ADDR_WIDTH = 10,
   parameter int unsigned MEM0_DATA_WIDTH = RowWidth,
   parameter int unsigned MEM1_DATA_WIDTH = 112,
   parameter int unsigned OC              = 64
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] rdata_i,
   output logic [MEM0_DATA_WIDTH-1:0]         mem0_d0,
   output logic [MEM0_ADDR_WIDTH-1:0]         mem0_addr0,
   output logic                               mem0_ce0,
   output logic                               mem0_we0,
   output logic                               done
);

   localparam int unsigned VldDepth    = PE_SIZE - 1;
   localparam int unsigned RowCntWidth = (OC > 1) ? $clog2(OC) : 1;

   // Memory 1 and the FIFO depth bound are part of the shared interface only.
   localparam int unsigned unused_params =
      FIFO_DEPTH + MEM1_DEPTH + MEM1_ADDR_WIDTH + MEM1_DATA_WIDTH;

   logic [MEM0_DATA_WIDTH-1:0] row_aligned;
   logic [VldDepth-1:0]        vld_q;
   logic                       wr_valid;

   logic [MEM0_DATA_WIDTH-1:0] d0_q, d0_d;
   logic [MEM0_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RowCntWidth-1:0]     row_cnt_q, row_cnt_d;
   logic                       ce_q, ce_d;
   logic                       done_q, done_d;

   // Lane b arrives b cycles before lane 0, so it is held back b cycles.
   for (genvar b = 0; b < int'(PE_SIZE); b++) begin : g_lane
      lane_delay #(
         .DELAY(b),
         .WIDTH(FIFO_DATA_WIDTH)
      ) u_lane_delay (
         .clk   (clk),
         .rst_n (rst_n),
         .data_i(rdata_i[b*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]),
         .data_o(row_aligned[b*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[VldDepth-2:0], en};
      end
   end

   assign wr_valid = vld_q[VldDepth-1];

   always_comb begin
      d0_d      = d0_q;
      addr_d    = addr_q;
      row_cnt_d = row_cnt_q;
      ce_d      = wr_valid;
      done_d    = 1'b0;

      // The presented address stays put until the write it belongs to retires.
      if (ce_q) begin
         if (addr_q == MEM0_ADDR_WIDTH'(MEM0_DEPTH - 1)) begin
            addr_d = '0;
         end else begin
            addr_d = addr_q + MEM0_ADDR_WIDTH'(1);
         end
      end

      if (wr_valid) begin
         d0_d = row_aligned;
         if (row_cnt_q == RowCntWidth'(OC - 1)) begin
            row_cnt_d = '0;
            done_d    = 1'b1;
         end else begin
            row_cnt_d = row_cnt_q + RowCntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d0_q      <= '0;
         addr_q    <= '0;
         row_cnt_q <= '0;
         ce_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         d0_q      <= d0_d;
         addr_q    <= addr_d;
         row_cnt_q <= row_cnt_d;
         ce_q      <= ce_d;
         done_q    <= done_d;
      end
   end

   assign mem0_d0    = d0_q;
   assign mem0_addr0 = addr_q;
   assign mem0_ce0   = ce_q;
   assign mem0_we0   = ce_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sa_data_mover.sv
// Directed self-checking bench for sa_data_mover: ramp de-skew, idle, single pulse,
// OC/done boundary, address wrap and asynchronous reset mid-stream.
module tb_sa_data_mover;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [111:0] rdata_i;
   logic [111:0] mem0_d0;
   logic [9:0]   mem0_addr0;
   logic         mem0_ce0;
   logic         mem0_we0;
   logic         done;

   int n_checks;
   int n_errors;
   int cyc;
   int n_we_mismatch;
   int n_done_orphan;

   logic [9:0]   wr_addr [$];
   logic [111:0] wr_data [$];
   logic         wr_done [$];
   int           wr_cyc  [$];

   sa_data_mover u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdata_i   (rdata_i),
      .mem0_d0   (mem0_d0),
      .mem0_addr0(mem0_addr0),
      .mem0_ce0  (mem0_ce0),
      .mem0_we0  (mem0_we0),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and log any write presented after it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (mem0_we0 !== mem0_ce0) n_we_mismatch++;
      if (done === 1'b1 && mem0_ce0 !== 1'b1) n_done_orphan++;
      if (mem0_ce0 === 1'b1) begin
         wr_addr.push_back(mem0_addr0);
         wr_data.push_back(mem0_d0);
         wr_done.push_back(done);
         wr_cyc.push_back(cyc);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_done.delete();
      wr_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      en      = 1'b0;
      rdata_i = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      clear_log();
   endtask

   task automatic test_ramp();
      logic [111:0] prev;
      logic [111:0] nv;
      logic [111:0] exp_row;
      logic [7:0]   b;
      int           s;
      int           n_done;
      prev = '0;
      s    = cyc + 1;
      for (int i = 0; i < 31; i++) begin
         nv = prev >> 8;
         if (i < 14) nv = nv | (112'(i) << 104);
         en      = (i < 14);
         rdata_i = nv;
         prev    = nv;
         tick();
      end
      en = 1'b0;
      check_eq("ramp_count", 128'(wr_addr.size()), 128'd14);
      for (int i = 0; i < 14; i++) begin
         if (i < wr_addr.size()) begin
            b       = 8'(i);
            exp_row = {14{b}};
            check_eq($sformatf("ramp_addr[%0d]", i), 128'(wr_addr[i]), 128'(i));
            check_eq($sformatf("ramp_data[%0d]", i), 128'(wr_data[i]), 128'(exp_row));
         end
      end
      if (wr_cyc.size() > 0) check_eq("ramp_latency", 128'(wr_cyc[0] - s), 128'd13);
      n_done = 0;
      foreach (wr_done[i]) if (wr_done[i]) n_done++;
      check_eq("ramp_no_done", 128'(n_done), 128'd0);
      check_eq("ramp_addr_after", 128'(mem0_addr0), 128'd14);
   endtask

   task automatic test_idle();
      for (int i = 0; i < 40; i++) begin
         en      = 1'b0;
         rdata_i = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      check_eq("idle_writes", 128'(wr_addr.size()), 128'd0);
      check_eq("idle_addr", 128'(mem0_addr0), 128'd0);
   endtask

   task automatic test_pulse();
      logic [111:0] drv [14];
      logic [111:0] exp_row;
      int           s;
      s = cyc + 1;
      for (int k = 0; k < 30; k++) begin
         en      = (k == 0);
         rdata_i = {$urandom, $urandom, $urandom, $urandom};
         if (k < 14) drv[k] = rdata_i;
         tick();
      end
      en = 1'b0;
      // Lane b of the row lives in the word driven (13-b) edges after the pulse.
      for (int b = 0; b < 14; b++) begin
         exp_row[b*8 +: 8] = drv[13-b][b*8 +: 8];
      end
      check_eq("pulse_writes", 128'(wr_addr.size()), 128'd1);
      if (wr_addr.size() > 0) begin
         check_eq("pulse_latency", 128'(wr_cyc[0] - s), 128'd13);
         check_eq("pulse_addr", 128'(wr_addr[0]), 128'd0);
         check_eq("pulse_data", 128'(wr_data[0]), 128'(exp_row));
      end
      check_eq("pulse_addr_after", 128'(mem0_addr0), 128'd1);
   endtask

   task automatic test_stream();
      int n_done;
      for (int k = 0; k < 917; k++) begin
         en      = (k < 897);
         rdata_i = {14{8'h5a}};
         tick();
      end
      en = 1'b0;
      check_eq("stream_writes", 128'(wr_addr.size()), 128'd897);
      if (wr_addr.size() >= 897) begin
         check_eq("wrap_addr_895", 128'(wr_addr[895]), 128'd895);
         check_eq("wrap_addr_896", 128'(wr_addr[896]), 128'd0);
         check_eq("stream_back_to_back", 128'(wr_cyc[896] - wr_cyc[0]), 128'd896);
         check_eq("done_row63", 128'(wr_done[63]), 128'd1);
         check_eq("done_row62", 128'(wr_done[62]), 128'd0);
         check_eq("done_row64", 128'(wr_done[64]), 128'd0);
         check_eq("done_row127", 128'(wr_done[127]), 128'd1);
         check_eq("stream_data_last", 128'(wr_data[896]), 128'(112'({14{8'h5a}})));
      end
      n_done = 0;
      foreach (wr_done[i]) if (wr_done[i]) n_done++;
      check_eq("done_total", 128'(n_done), 128'd14);
      check_eq("stream_addr_after", 128'(mem0_addr0), 128'd1);
   endtask

   task automatic test_mid_reset();
      logic [111:0] prev;
      logic [111:0] nv;
      int           s;
      prev = '0;
      for (int i = 0; i < 5; i++) begin
         nv      = (prev >> 8) | (112'(i) << 104);
         en      = 1'b1;
         rdata_i = nv;
         prev    = nv;
         tick();
      end
      check_eq("pre_rst_addr", 128'(mem0_addr0), 128'd1);
      check_eq("pre_rst_d0", 128'(mem0_d0), 128'(112'({14{8'h5a}})));
      rdata_i = (prev >> 8) | (112'd5 << 104);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_d0", 128'(mem0_d0), 128'd0);
      check_eq("async_rst_addr", 128'(mem0_addr0), 128'd0);
      check_eq("async_rst_ce", 128'(mem0_ce0), 128'd0);
      check_eq("async_rst_we", 128'(mem0_we0), 128'd0);
      check_eq("async_rst_done", 128'(done), 128'd0);
      tick();
      tick();
      rst_n = 1'b1;
      en    = 1'b0;
      clear_log();
      for (int i = 0; i < 20; i++) tick();
      check_eq("post_rst_no_write", 128'(wr_addr.size()), 128'd0);
      s  = cyc + 1;
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      check_eq("post_rst_writes", 128'(wr_addr.size()), 128'd1);
      if (wr_addr.size() > 0) begin
         check_eq("post_rst_latency", 128'(wr_cyc[0] - s), 128'd13);
         check_eq("post_rst_addr", 128'(wr_addr[0]), 128'd0);
      end
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      cyc           = 0;
      n_we_mismatch = 0;
      n_done_orphan = 0;
      en            = 1'b0;
      rdata_i       = '0;
      rst_n         = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_d0", 128'(mem0_d0), 128'd0);
      check_eq("rst_addr", 128'(mem0_addr0), 128'd0);
      check_eq("rst_ce", 128'(mem0_ce0), 128'd0);
      check_eq("rst_we", 128'(mem0_we0), 128'd0);
      check_eq("rst_done", 128'(done), 128'd0);

      do_reset();
      test_ramp();
      do_reset();
      test_idle();
      do_reset();
      test_pulse();
      do_reset();
      test_stream();
      clear_log();
      test_mid_reset();

      check_eq("we_equals_ce", 128'(n_we_mismatch), 128'd0);
      check_eq("done_only_with_write", 128'(n_done_orphan), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sa_data_mover.md
# sa_data_mover

Output-side data mover for the PE_SIZE×PE_SIZE systolic array (GEMM block). It accepts the array's diagonally skewed result vector (one FIFO_DATA_WIDTH element per lane per cycle) and de-skews the lanes into aligned rows. It writes one aligned row per valid input cycle into output memory 0 through a single-port write interface with a wrapping address counter.

## Interface
- FIFO_DATA_WIDTH, 8 — bits per lane element
- FIFO_DEPTH, 14 — maximum per-lane skew storage; must be ≥ PE_SIZE-1
- PE_SIZE, 14 — number of lanes
- MEM0_DEPTH, 896 — rows in memory 0; the address wraps here
- MEM1_DEPTH, 896 — reserved, unused
- MEM0_ADDR_WIDTH, 10 — memory 0 address width
- MEM1_ADDR_WIDTH, 10 — reserved, unused
- MEM0_DATA_WIDTH, 112 — must equal FIFO_DATA_WIDTH*PE_SIZE
- MEM1_DATA_WIDTH, 112 — reserved, unused
- OC, 64 — rows per output tile; drives `done`

Ports:
- clk  in  1 — single clock, rising edge
- rst_n  in  1 — asynchronous, active-low reset
- en  in  1 — marks that lane PE_SIZE-1 of rdata_i carries the first element of a new row this cycle
- rdata_i  in  FIFO_DATA_WIDTH*PE_SIZE — skewed array output; lane b = bits [8b+7:8b]
- mem0_d0  out  MEM0_DATA_WIDTH — aligned row write data
- mem0_addr0  out  MEM0_ADDR_WIDTH — write address
- mem0_ce0  out  1 — memory enable
- mem0_we0  out  1 — write enable, equal to mem0_ce0
- done  out  1 — one-cycle pulse when the OC-th row of a tile is written

## Operation
- Skew convention: the row sampled with en at edge E has lane b present at edge E+(PE_SIZE-1-b). Lane PE_SIZE-1 arrives first and lane 0 arrives last.
- Lane b passes through a fixed delay of b cycles. The delay lines shift every cycle regardless of en.
- A valid shift register of depth PE_SIZE-1 tracks en.
- When the delayed valid bit is set, the aligned row is registered onto mem0_d0 and ce0/we0 are asserted for one cycle with the current address.
- After each write, the address increments and wraps from MEM0_DEPTH-1 to 0.
- A row counter runs from 0 to OC-1. On the OC-th write, done pulses alongside that write and the counter returns to 0.
- Rows with en=0 are never written. Gaps in en are allowed, and each row is handled independently.
- Data bytes pass through unmodified, with no arithmetic.

## Timing
- Latency: the row flagged by en at edge E is driven on mem0_d0, with ce0=we0=1, after edge E+PE_SIZE-1.
- For every lane b, mem0_d0[8b+7:8b] after that edge equals rdata_i lane b as sampled at edge E+(PE_SIZE-1-b).
- en held high for consecutive cycles produces one write per cycle.
- mem0_addr0 holds the address of the row currently presented. It advances on the edge after each write.
- Reset values: mem0_d0=0, mem0_addr0=0, ce0=we0=0, done=0. All delay lines, the valid pipeline and the row counter clear to 0.
- Reset mid-stream discards all in-flight rows. No write occurs until PE_SIZE-1 cycles after en is next sampled high.

## Structure
- Shared GEMM package: lane width, PE_SIZE, and the derived row-width constant.
- Sub-module `lane_delay`, parameterized by DELAY and WIDTH: a shift register, with DELAY=0 as a wire. Instantiate it PE_SIZE times with DELAY=b.
- Address counter, row counter and output registers live in the top level.

## Test plan
- Skewed ramp: after reset, hold en=1 from cycle 0. In cycle i (0≤i≤13), rdata_i = (previous >> 8) | (i << 104); after that, shift in zeros. Required response: writes at addresses 0..13 with mem0_d0 = {14{8'hii}}, i.e. 0x00…00, 0x0101…01, …, 0x0D0D…0D. The first write occurs 13 cycles after en is first sampled.
- en low throughout with random rdata_i: ce0 and we0 never assert, and the address stays 0.
- Single-cycle en pulse: exactly one write, 13 cycles later, at address 0. The address becomes 1 afterwards.
- Address wrap: preset the stream so 897 rows are written. Required response: the 896th row goes to address 895 and the 897th to address 0.
- OC boundary: stream 64 consecutive rows. Required response: done pulses exactly with the 64th write, and again with the 128th.
- Reset mid-stream: assert rst_n=0 at cycle 5 of the ramp. Required response: all outputs are 0 immediately (asynchronous), and no write occurs after release until new en plus 13 cycles.
